// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: capture controller for the system ILA.
// Qualified samples go circularly into the sample RAM through port A. After
// a trigger sample, a programmable number of further samples is stored and
// then capture stops. The status outputs let the host read the trace back
// in order through port B.
//
// Handshake: there is no back-pressure. A sample is consumed on every clock
// edge where sample_valid=1 and the controller is ARMED or POST. The write
// appears on port A one cycle later as a single-cycle ram_wea strobe.
module ila_capture_ctrl #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              trig_in,
    input  logic              cfg_arm,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_post_cnt,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic              ram_wea,
    output logic [1:0]        sts_state,
    output logic              sts_done,
    output logic [ADDR_W-1:0] sts_trig_addr,
    output logic [ADDR_W-1:0] sts_start_addr,
    output logic              sts_wrapped
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [ADDR_W-1:0] post_q, post_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic              wrapped_q, wrapped_d;

    // Per-cycle view after a possible restart: the pointer, wrap flag, state
    // and post count that this cycle's sample (if any) is processed against.
    logic [1:0]        eff_state;
    logic [ADDR_W-1:0] eff_ptr;
    logic [ADDR_W-1:0] eff_post;
    logic              eff_wrapped;
    logic              take;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              wrap_nxt;
    logic              done_now;

    // Next-state logic: abort first, then restart on arm, then sample handling.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        remain_d     = remain_q;
        post_d       = post_q;
        wea_d        = 1'b0;
        addra_d      = addra_q;
        dina_d       = dina_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        wrapped_d    = wrapped_q;
        eff_state    = state_q;
        eff_ptr      = wr_ptr_q;
        eff_post     = post_q;
        eff_wrapped  = wrapped_q;
        take         = 1'b0;
        ptr_nxt      = wr_ptr_q + 1'b1;
        wrap_nxt     = wrapped_q;
        done_now     = 1'b0;

        if (cfg_abort) begin
            // Status registers are deliberately left alone for post-mortem readout.
            state_d = S_IDLE;
        end else begin
            // A sample is only stored while a capture is in flight.
            take = (state_q == S_ARMED) || (state_q == S_POST);
            if (cfg_arm) begin
                eff_state    = S_ARMED;
                eff_ptr      = '0;
                eff_post     = cfg_post_cnt;
                eff_wrapped  = 1'b0;
                state_d      = S_ARMED;
                wr_ptr_d     = '0;
                post_d       = cfg_post_cnt;
                wrapped_d    = 1'b0;
                trig_addr_d  = '0;
                start_addr_d = '0;
            end
            if (take && sample_valid) begin
                ptr_nxt   = eff_ptr + 1'b1;
                wrap_nxt  = eff_wrapped | (eff_ptr == LAST_ADDR);
                wea_d     = 1'b1;
                addra_d   = eff_ptr;
                dina_d    = sample_in;
                wr_ptr_d  = ptr_nxt;
                wrapped_d = wrap_nxt;
                if (eff_state == S_ARMED) begin
                    if (trig_in) begin
                        trig_addr_d = eff_ptr;
                        remain_d    = eff_post;
                        if (eff_post == '0) begin
                            done_now = 1'b1;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end else begin
                    remain_d = remain_q - 1'b1;
                    if (remain_q == ADDR_W'(1)) begin
                        done_now = 1'b1;
                    end
                end
                if (done_now) begin
                    state_d      = S_DONE;
                    start_addr_d = wrap_nxt ? ptr_nxt : '0;
                end
            end
        end
    end

    // sts_done lags entry into DONE by one cycle so the final RAM write has landed.
    always_comb begin
        done_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    // State and registered port A / status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            remain_q     <= '0;
            post_q       <= '0;
            wea_q        <= 1'b0;
            addra_q      <= '0;
            dina_q       <= '0;
            done_q       <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            wrapped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            remain_q     <= remain_d;
            post_q       <= post_d;
            wea_q        <= wea_d;
            addra_q      <= addra_d;
            dina_q       <= dina_d;
            done_q       <= done_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            wrapped_q    <= wrapped_d;
        end
    end

    assign ram_addra      = addra_q;
    assign ram_dina       = dina_q;
    assign ram_wea        = wea_q;
    assign sts_state      = state_q;
    assign sts_done       = done_q;
    assign sts_trig_addr  = trig_addr_q;
    assign sts_start_addr = start_addr_q;
    assign sts_wrapped    = wrapped_q;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Bench for ila_capture_ctrl with DEPTH=16, DATA_W=8. The expected write
// sequence of a capture is derived from the sample stream: the k-th valid
// sample lands at k mod DEPTH. The capture ends with sample t+post (t is the
// trigger index). Final status follows from the total sample count.
module tb_ila_capture_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic              sample_valid = 1'b0;
    logic              trig_in = 1'b0;
    logic              cfg_arm = 1'b0;
    logic              cfg_abort = 1'b0;
    logic [ADDR_W-1:0] cfg_post_cnt = '0;
    logic [ADDR_W-1:0] ram_addra;
    logic [DATA_W-1:0] ram_dina;
    logic              ram_wea;
    logic [1:0]        sts_state;
    logic              sts_done;
    logic [ADDR_W-1:0] sts_trig_addr;
    logic [ADDR_W-1:0] sts_start_addr;
    logic              sts_wrapped;

    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    ila_capture_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .trig_in(trig_in), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
        .cfg_post_cnt(cfg_post_cnt), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_wea(ram_wea), .sts_state(sts_state), .sts_done(sts_done),
        .sts_trig_addr(sts_trig_addr), .sts_start_addr(sts_start_addr),
        .sts_wrapped(sts_wrapped)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int addr, input logic [DATA_W-1:0] d);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(addr % DEPTH);
        exp_q.push_back({a, d});
    endtask

    // Drive one cycle of sample inputs, return at the following negedge.
    task automatic send(input logic v, input logic [DATA_W-1:0] d, input logic tr);
        sample_valid = v;
        sample_in    = d;
        trig_in      = tr;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && ram_wea) begin
            if (exp_q.size() == 0) begin
                check("unexp_wr", 32'(ram_wea), 32'd0);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(ram_addra), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                check("wr_data", 32'(ram_dina), 32'(e[DATA_W-1:0]));
            end
        end
    end

    // One complete capture. dens<0 means valid alternates every cycle.
    // arm_smp sends sample 0 in the arm cycle (DUT must be ARMED/POST then).
    task automatic run_capture(input int post, input int t, input int dens,
                               input bit arm_smp, input bit directed);
        int n_total;
        int k;
        int cyc;
        logic v;
        logic [DATA_W-1:0] d;
        n_total = t + post + 1;
        k = 0;
        cyc = 0;
        cfg_post_cnt = ADDR_W'(post);
        cfg_arm = 1'b1;
        if (arm_smp) begin
            d = directed ? DATA_W'(0) : DATA_W'($urandom);
            push_exp(0, d);
            k = 1;
            send(1'b1, d, t == 0);
        end else begin
            send(1'b0, DATA_W'($urandom), 1'($urandom));
        end
        cfg_arm = 1'b0;
        if (!arm_smp) begin
            check("arm_state", 32'(sts_state), 32'd1);
            check("arm_trig", 32'(sts_trig_addr), 32'd0);
            check("arm_wrap", 32'(sts_wrapped), 32'd0);
            check("arm_start", 32'(sts_start_addr), 32'd0);
            check("arm_done", 32'(sts_done), 32'd0);
        end
        while (k < n_total) begin
            if (dens < 0) v = 1'(cyc);
            else v = ($urandom_range(0, 99) < dens) || (cyc > 200);
            cyc++;
            if (v) begin
                d = directed ? DATA_W'(k) : DATA_W'($urandom);
                push_exp(k, d);
                send(1'b1, d, (k == t) || (k > t && 1'($urandom)));
                k++;
            end else begin
                send(1'b0, DATA_W'($urandom), 1'($urandom));
            end
        end
        // Final write is now on port A; done must still be low.
        check("end_state", 32'(sts_state), 32'd3);
        check("end_done_early", 32'(sts_done), 32'd0);
        send(1'($urandom), DATA_W'($urandom), 1'($urandom));
        check("done", 32'(sts_done), 32'd1);
        for (int i = 0; i < 3; i++) send(1'($urandom), DATA_W'($urandom), 1'($urandom));
        check("trig_addr", 32'(sts_trig_addr), 32'(t % DEPTH));
        check("wrapped", 32'(sts_wrapped), 32'(n_total >= DEPTH));
        check("start_addr", 32'(sts_start_addr), (n_total >= DEPTH) ? 32'(n_total % DEPTH) : 32'd0);
        check("hold_state", 32'(sts_state), 32'd3);
        check("hold_done", 32'(sts_done), 32'd1);
        check("pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", 32'(sts_state), 32'd0);
        check("rst_outs", 32'({ram_wea, ram_addra, ram_dina, sts_done, sts_trig_addr,
                               sts_start_addr, sts_wrapped}), 32'd0);
        // No writes in IDLE.
        for (int i = 0; i < 3; i++) send(1'b1, DATA_W'(i + 1), 1'b1);

        // Trigger on sample 5, three post samples.
        run_capture(3, 5, 100, 1'b0, 1'b1);
        // Wrap: trigger on sample 19, four post samples.
        run_capture(4, 19, 100, 1'b0, 1'b1);
        // post_cnt=0, trigger on first sample: straight to DONE.
        run_capture(0, 0, 100, 1'b0, 1'b1);
        // Alternating valid, stray triggers only on invalid cycles.
        run_capture(2, 6, -1, 1'b0, 1'b1);
        // Exactly DEPTH samples in total: wrapped with start at 0.
        run_capture(15, 0, 100, 1'b0, 1'b1);

        // Abort during POST: same-cycle sample dropped, status retained.
        cfg_post_cnt = 4'd8;
        cfg_arm = 1'b1;
        send(1'b0, 8'h00, 1'b0);
        cfg_arm = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_exp(k, DATA_W'(k + 8'h40));
            send(1'b1, DATA_W'(k + 8'h40), k == 2);
        end
        check("post_state", 32'(sts_state), 32'd2);
        cfg_abort = 1'b1;
        send(1'b1, 8'hee, 1'b0);
        cfg_abort = 1'b0;
        check("abort_state", 32'(sts_state), 32'd0);
        check("abort_done", 32'(sts_done), 32'd0);
        check("abort_trig", 32'(sts_trig_addr), 32'd2);
        for (int i = 0; i < 4; i++) send(1'b1, DATA_W'($urandom), 1'($urandom));
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        // Arm and abort together: abort wins, status untouched.
        cfg_arm = 1'b1;
        cfg_abort = 1'b1;
        send(1'b1, 8'h11, 1'b1);
        cfg_arm = 1'b0;
        cfg_abort = 1'b0;
        check("armabort_state", 32'(sts_state), 32'd0);
        check("armabort_trig", 32'(sts_trig_addr), 32'd2);
        send(1'b1, 8'h22, 1'b0);
        // Re-arm from IDLE.
        run_capture(3, 2, 70, 1'b0, 1'b0);

        // Restart while in POST: arm-cycle sample becomes address 0.
        cfg_post_cnt = 4'd6;
        cfg_arm = 1'b1;
        send(1'b0, 8'h00, 1'b0);
        cfg_arm = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_exp(k, DATA_W'(k + 8'h80));
            send(1'b1, DATA_W'(k + 8'h80), k == 1);
        end
        run_capture(2, 3, 80, 1'b1, 1'b0);

        // Randomized captures.
        for (int r = 0; r < 10; r++) begin
            run_capture($urandom_range(0, 15), $urandom_range(0, 20),
                        $urandom_range(30, 100), 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of POST.
        cfg_post_cnt = 4'd10;
        cfg_arm = 1'b1;
        send(1'b0, 8'h00, 1'b0);
        cfg_arm = 1'b0;
        for (int k = 0; k < 9; k++) begin
            push_exp(k, DATA_W'(k + 1));
            send(1'b1, DATA_W'(k + 1), k == 5);
        end
        check("pre_rst_state", 32'(sts_state), 32'd2);
        sample_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_state", 32'(sts_state), 32'd0);
        check("arst_outs", 32'({ram_wea, ram_addra, ram_dina, sts_done, sts_trig_addr,
                                sts_start_addr, sts_wrapped}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b1, DATA_W'($urandom), 1'b1);
        check("post_rst_state", 32'(sts_state), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ila_capture_ctrl.md
# ila_capture_ctrl

Capture controller for the system ILA: qualifies incoming samples, writes them circularly into the dual-port sample RAM through its port A, and stops after a programmable number of post-trigger samples. Host readout uses RAM port B using the status outputs (trigger address, oldest-sample address, wrap flag) produced here. Sits between the probe mux and the sample RAM.

## Interface

- DATA_W, 64, sample width; equals RAM_WIDTH of the sample RAM
- DEPTH, 512, sample RAM depth; power of two, ≥4
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  single clock for all logic
- rst_n  in  1  reset, asynchronous, active-low
- sample_in  in  DATA_W  probe data
- sample_valid  in  1  sample_in qualifier; only valid samples are stored or counted
- trig_in  in  1  trigger condition; honoured only with sample_valid=1
- cfg_arm  in  1  single-cycle pulse: start new capture
- cfg_abort  in  1  single-cycle pulse: stop capture, return to IDLE
- cfg_post_cnt  in  ADDR_W  samples stored after the trigger sample; latched on arm
- ram_addra  out  ADDR_W  RAM port A address
- ram_dina  out  DATA_W  RAM port A write data
- ram_wea  out  1  RAM port A write strobe
- sts_state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE
- sts_done  out  1  capture complete, RAM contents stable
- sts_trig_addr  out  ADDR_W  address holding the trigger sample
- sts_start_addr  out  ADDR_W  address of oldest valid sample
- sts_wrapped  out  1  write pointer has wrapped at least once this capture

## Operation

- Reset: state IDLE; all outputs 0; wr_ptr=0, post counter 0.
- IDLE: no writes. cfg_arm → ARMED; wr_ptr, sts_wrapped, sts_trig_addr, sts_start_addr cleared; cfg_post_cnt latched.
- ARMED: every valid sample written at wr_ptr; wr_ptr+1 mod DEPTH; DEPTH-1→0 sets sts_wrapped (sticky). Valid sample with trig_in=1: written normally, sts_trig_addr=its address, remaining=latched post_cnt; remaining=0 → DONE, else → POST.
- POST: trig_in ignored; each valid sample written, remaining−1; write with remaining=1 → DONE.
- DONE: no writes; holds status until cfg_arm (restart as from IDLE) or cfg_abort (→ IDLE, status retained).
- sts_start_addr set on entering DONE: wrapped ? wr_ptr after final write (next address) : 0.
- cfg_abort in any state → IDLE; takes priority over cfg_arm and any same-cycle sample (that sample not written). sts_done cleared.
- cfg_arm in ARMED/POST: restart capture (pointer 0, status cleared); same-cycle sample is the first sample of the new capture (written at address 0).
- Post-trigger total = 1 + post_cnt ≤ DEPTH, so the trigger sample is never overwritten; with post_cnt=DEPTH-1 the oldest sample is the trigger sample.

## Timing

- Write path registered: valid sample at edge N → ram_wea=1, ram_addra, ram_dina valid in cycle after N (one-cycle latency); ram_wea is a single-cycle strobe per sample, 0 otherwise.
- sts_state, sts_trig_addr, sts_wrapped update on the same edge the corresponding write is registered.
- sts_done rises one cycle after the final ram_wea strobe, so the RAM has committed the last sample when the host observes it; stays 1 while in DONE.
- Back-to-back valid samples sustained at one per cycle, no bubbles.
- cfg_arm/cfg_abort act on the edge where sampled; effect visible next cycle.

## Test plan

- Reset: assert rst_n=0 mid-POST with ram_wea toggling → all outputs 0 immediately (asynchronous), state IDLE after release, no writes until arm.
- DEPTH=16, DATA_W=8, post_cnt=3, arm, continuous valid samples 0,1,2…, trig_in with sample 5 → 9 strobes at addr 0..8 data 0..8, sts_trig_addr=5, sts_wrapped=0, sts_start_addr=0, sts_done one cycle after last strobe.
- Same config, post_cnt=4, trigger on sample 19 → 24 strobes, last at addr 7 data 23, sts_trig_addr=3, sts_wrapped=1, sts_start_addr=8.
- post_cnt=0, trig_in on first valid sample → exactly one strobe at addr 0, state ARMED→DONE directly.
- sample_valid toggling every other cycle, trig_in pulsed only while valid=0 → no trigger, no writes in invalid cycles; then trig_in with valid sample 6 → sts_trig_addr=6.
- cfg_abort during POST → ram_wea stays 0 thereafter, sts_done=0, IDLE; cfg_arm+cfg_abort same cycle → IDLE; re-arm → first write at addr 0, sts_wrapped=0.
